// File: rtl/fetch_pkg.sv
// Shared types for the RV32I fetch stage: FSM state encoding, NOP word and the
// {pc, inst} entry held in the instruction buffer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    FLUSH,
    HALT
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

endpackage

// File: rtl/fifo_instr.sv
// Small synchronous FIFO of fetched {pc, inst} entries with a synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo_instr
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  entry_t                 din,
  output entry_t                 dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // NOTE: sequential state is updated with <= only, so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count qualifies every read, and
  // leaving the reset off lets this map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/etapa_fetch.sv
// RV32I instruction fetch stage: PC, single-outstanding imem reads, buffered
// handoff to decode, redirect flush. Optional FETCH_MISALIGN_CHECK_EN halts on
// misaligned redirects.
module etapa_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_misaligned
);

  localparam int             CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  FULL = CW'(FIFO_DEPTH);

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          halt_drain;
  logic          misaligned_q;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  entry_t        head;
  entry_t        push_entry;
  logic          push;
  logic          pop;
  logic          resp_pending;
  logic          misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = redirect && (redirect_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign inst_valid  = (count != '0);
  assign pop         = inst_valid && inst_ready;
  assign push        = (state == WAIT_RESP) && imem_rvalid && !redirect;
  assign count_after = count + CW'(push) - CW'(pop);
  assign push_entry  = '{pc: req_pc, inst: imem_rdata};

  // A response is still owed after this cycle: the one just granted, or one
  // being waited on that has not arrived this cycle.
  // NOTE: defaulting every always_comb output first rules out inferred latches.
  always_comb begin
    resp_pending = 1'b0;
    case (state)
      REQ:             resp_pending = imem_gnt;
      WAIT_RESP, FLUSH: resp_pending = !imem_rvalid;
      HALT:            resp_pending = halt_drain && !imem_rvalid;
      default:         resp_pending = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC & 32'hFFFF_FFFC;
      req_pc       <= RESET_PC & 32'hFFFF_FFFC;
      imem_req     <= 1'b0;
      halt_drain   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      if (redirect) begin
        pc <= redirect_pc & 32'hFFFF_FFFC;
        if (misalign) begin
          state        <= HALT;
          imem_req     <= 1'b0;
          halt_drain   <= resp_pending;
          misaligned_q <= 1'b1;
        end else if (resp_pending) begin
          state      <= FLUSH;
          imem_req   <= 1'b0;
          halt_drain <= 1'b0;
        end else begin
          state      <= REQ;
          imem_req   <= 1'b1;
          halt_drain <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (count < FULL) begin
              state    <= REQ;
              imem_req <= 1'b1;
            end
          end
          REQ: begin
            if (imem_gnt) begin
              req_pc   <= pc;
              pc       <= pc + 32'd4;
              state    <= WAIT_RESP;
              imem_req <= 1'b0;
            end
          end
          WAIT_RESP: begin
            if (imem_rvalid) begin
              if (count_after < FULL) begin
                state    <= REQ;
                imem_req <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
          FLUSH: begin
            if (imem_rvalid) begin
              state    <= REQ;
              imem_req <= 1'b1;
            end
          end
          HALT: begin
            if (imem_rvalid) halt_drain <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        endcase
      end
    end
  end

  fifo_instr #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .din   (push_entry),
    .dout  (head),
    .count (count)
  );

  assign imem_addr        = pc;
  assign inst             = inst_valid ? head.inst : NOP;
  assign inst_pc          = inst_valid ? head.pc : 32'h0000_0000;
  assign fetch_misaligned = misaligned_q;

endmodule
